// File: rtl/multu_seq.sv
// ----------------------------------------------------------------------------
// multu_seq : sequential unsigned shift-add multiplier for the MULTU
//             instruction. One multiplier bit is consumed per clock, so a
//             product takes WIDTH clocks from the accepting edge.
//
// Ports:
//   Clk       in   1        system clock, rising edge
//   Reset     in   1        asynchronous active-low reset (0 = reset)
//   Start     in   1        sample OpA/OpB and begin a multiply (IDLE/DONE only)
//   OpA       in   WIDTH    multiplicand, unsigned
//   OpB       in   WIDTH    multiplier, unsigned
//   Busy      out  1        high while iterating
//   Done      out  1        one-cycle pulse: MultuAns holds a new product
//   MultuAns  out  2*WIDTH  registered product feeding the Hi/Lo register
// ----------------------------------------------------------------------------
module multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   MultuAns
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   ans_r;
    logic [2*WIDTH-1:0]   sum_s;
    logic                 load_s;

    // Outputs are decoded straight from the state register, so Start and the
    // operands never reach an output combinationally.
    assign Busy     = (state_r == RUN);
    assign Done     = (state_r == DONE);
    assign MultuAns = ans_r;

    // Post-accumulation value of the current iteration; this is also the
    // final product on the last iteration.
    assign sum_s = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and operand-load decision.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                // Start is deliberately ignored here: the in-flight op wins.
                if (cnt_r == LAST_CNT) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                // Back-to-back issue: a new op can be accepted in the Done cycle.
                if (Start) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
                load_s       = 1'b0;
            end
        endcase
    end

    // Shift-add datapath and result register; MultuAns only moves on the
    // completion edge so the Hi/Lo register can sample it every clock.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            ans_r    <= {(2*WIDTH){1'b0}};
        end else if (load_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, OpA};
            mplier_r <= OpB;
            prod_r   <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == RUN) begin
            prod_r   <= sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
                ans_r <= sum_s;
            end
        end
    end

endmodule
